// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states, latched request payload.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = XLEN / 8;

  typedef logic [1:0] lsu_size_t;

  localparam lsu_size_t LSU_SIZE_BYTE = 2'd0;
  localparam lsu_size_t LSU_SIZE_HALF = 2'd1;
  localparam lsu_size_t LSU_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            store;
    lsu_size_t       size;
    logic            is_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Controller-side request/response and data-memory bus signals of the LSU.
interface lsu_if;
  import lsu_pkg::*;

  logic              reqValid;
  logic              reqStore;
  lsu_size_t         reqSize;
  logic              reqUnsigned;
  logic [XLEN-1:0]   reqAddr;
  logic [XLEN-1:0]   reqWdata;
  logic              respValid;
  logic [XLEN-1:0]   respRdata;
  logic              respErr;
  logic              mem_reqValid;
  logic              mem_reqReady;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_wen;
  logic [NLANES-1:0] mem_wmask;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_respValid;
  logic [XLEN-1:0]   mem_rdata;

  // LSU side
  modport slave (
    input  reqValid, reqStore, reqSize, reqUnsigned, reqAddr, reqWdata,
    output respValid, respRdata, respErr,
    output mem_reqValid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  mem_reqReady, mem_respValid, mem_rdata
  );

  // Controller plus memory side
  modport master (
    output reqValid, reqStore, reqSize, reqUnsigned, reqAddr, reqWdata,
    input  respValid, respRdata, respErr,
    input  mem_reqValid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output mem_reqReady, mem_respValid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// LSU_MISALIGN_EN: flag misaligned half/word accesses instead of force-aligning them.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t         size_i,
  input  logic [1:0]        off_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [NLANES-1:0] wmask_c_o,
  output logic [XLEN-1:0]   wdata_c_o,
  output logic [XLEN-1:0]   rdata_c_o,
  output logic              misalign_c_o
);

  logic            is_byte;
  logic            is_half;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  always_comb begin
    is_byte = (size_i == LSU_SIZE_BYTE);
    is_half = (size_i == LSU_SIZE_HALF);
`ifdef LSU_MISALIGN_EN
    off          = off_i;
    misalign_c_o = (is_half && off_i[0]) || (!is_byte && !is_half && (off_i != 2'd0));
`else
    // Half and word accesses ignore the low address bits below their size
    off          = is_byte ? off_i : (is_half ? {off_i[1], 1'b0} : 2'd0);
    misalign_c_o = 1'b0;
`endif
    shifted = rdata_i >> {off, 3'b000};

    if (is_byte) begin
      wmask_c_o = 4'(4'b0001 << off);
      wdata_c_o = {4{wdata_i[7:0]}};
      rdata_c_o = unsigned_i ? XLEN'(shifted[7:0]) : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      wmask_c_o = 4'(4'b0011 << off);
      wdata_c_o = {2{wdata_i[15:0]}};
      rdata_c_o = unsigned_i ? XLEN'(shifted[15:0]) : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      wmask_c_o = 4'b1111;
      wdata_c_o = wdata_i;
      rdata_c_o = rdata_i;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, one data-memory transaction, one-cycle response.
// LSU_MISALIGN_EN: misaligned accesses skip the bus and respond with respErr.
module lsu
  import lsu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  lsu_if.slave lsu_bus
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  lsu_req_t          live, cur;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [NLANES-1:0] mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NLANES-1:0] wmask_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   rdata_c;
  logic              misalign_c;

  // Steering sees the live request while idle, the latched one afterwards
  always_comb begin
    live.store       = lsu_bus.reqStore;
    live.size        = lsu_bus.reqSize;
    live.is_unsigned = lsu_bus.reqUnsigned;
    live.addr        = lsu_bus.reqAddr;
    live.wdata       = lsu_bus.reqWdata;
    cur              = (state_q == LSU_IDLE) ? live : req_q;
  end

  lsu_align u_align (
    .size_i       (cur.size),
    .off_i        (cur.addr[1:0]),
    .unsigned_i   (cur.is_unsigned),
    .wdata_i      (cur.wdata),
    .rdata_i      (lsu_bus.mem_rdata),
    .wmask_c_o    (wmask_c),
    .wdata_c_o    (wdata_c),
    .rdata_c_o    (rdata_c),
    .misalign_c_o (misalign_c)
  );

  // Next state and registered outputs
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    mem_req_valid_d = 1'b0;
    mem_addr_d      = '0;
    mem_wen_d       = 1'b0;
    mem_wmask_d     = '0;
    mem_wdata_d     = '0;

    unique case (state_q)
      LSU_IDLE: begin
        if (lsu_bus.reqValid) begin
          req_d = live;
          if (misalign_c) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (lsu_bus.mem_reqReady) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (lsu_bus.mem_respValid) begin
          state_d      = LSU_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = req_q.store ? '0 : rdata_c;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    if (state_d == LSU_REQ) begin
      mem_req_valid_d = 1'b1;
      mem_addr_d      = {cur.addr[XLEN-1:2], 2'b00};
      mem_wen_d       = cur.store;
      mem_wmask_d     = cur.store ? wmask_c : '0;
      mem_wdata_d     = cur.store ? wdata_c : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= LSU_IDLE;
      req_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wmask_q     <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wmask_q     <= mem_wmask_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign lsu_bus.respValid    = resp_valid_q;
  assign lsu_bus.respErr      = resp_err_q;
  assign lsu_bus.respRdata    = resp_rdata_q;
  assign lsu_bus.mem_reqValid = mem_req_valid_q;
  assign lsu_bus.mem_addr     = mem_addr_q;
  assign lsu_bus.mem_wen      = mem_wen_q;
  assign lsu_bus.mem_wmask    = mem_wmask_q;
  assign lsu_bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus requests and responses, monitors pop and compare.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  logic clock = 1'b0;
  logic reset;
  lsu_if bus ();

  lsu dut (.clock(clock), .reset(reset), .lsu_bus(bus));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  bus_exp_t  mon_b;
  resp_exp_t mon_r;

  int resp_seen = 0, bus_accepts = 0;
  int resp_cyc = -1, first_bus_cyc = -1, valid_len = 0, cur_len = 0;
  logic prev_resp = 1'b0, prev_bus_valid = 1'b0;
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_mask;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit model_mis(input logic [1:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_EN
    return (int'(a[1:0]) % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_off(input logic [1:0] s, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    return lo - (lo % nbytes(s));
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] m;
    int off, nb;
    off = model_off(s, a);
    nb  = nbytes(s);
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + nb);
    return m;
  endfunction

  function automatic logic [31:0] model_lanes(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input bit u,
                                             input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v, keep;
    int bits;
    if (nbytes(s) == 4) return w;
    bits = 8 * nbytes(s);
    keep = (32'd1 << bits) - 32'd1;
    v    = (w >> (8 * model_off(s, a))) & keep;
    if (!u && v[bits-1]) v = v | ~keep;
    return v;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_resp      = 1'b0;
      prev_bus_valid = 1'b0;
    end else begin
      if (bus.respValid) begin
        resp_seen++;
        resp_cyc   = cyc;
        last_rdata = bus.respRdata;
        last_err   = bus.respErr;
        check("resp_single_cycle", 32'(prev_resp), 32'd0);
        if (resp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          mon_r = resp_q.pop_front();
          check("respRdata", bus.respRdata, mon_r.rdata);
          check("respErr", 32'(bus.respErr), 32'(mon_r.err));
        end
      end
      prev_resp = bus.respValid;

      if (bus.mem_reqValid) begin
        if (!prev_bus_valid) begin
          first_bus_cyc = cyc;
          cur_len       = 0;
        end
        cur_len++;
        if (bus_q.size() == 0) fail_now("unexpected_bus_req");
        else begin
          mon_b = bus_q[0];
          check("mem_addr", bus.mem_addr, mon_b.addr);
          check("mem_wen", 32'(bus.mem_wen), 32'(mon_b.wen));
          check("mem_wmask", 32'(bus.mem_wmask), 32'(mon_b.mask));
          if (mon_b.wen) check("mem_wdata", bus.mem_wdata, mon_b.wdata);
          if (bus.mem_reqReady) begin
            void'(bus_q.pop_front());
            bus_accepts++;
            valid_len  = cur_len;
            last_addr  = bus.mem_addr;
            last_mask  = bus.mem_wmask;
            last_wdata = bus.mem_wdata;
          end
        end
      end
      prev_bus_valid = bus.mem_reqValid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!bus.respValid && n < 20) begin
      step();
      n++;
    end
    if (!bus.respValid) fail_now("timeout_respValid");
    step();
  endtask

  task automatic txn(input bit issue, input bit store, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int rdly, input int pdly, input bit hold, input bit glitch);
    bit mis;
    int n;
    bus_exp_t  be;
    resp_exp_t re;
    mis = model_mis(size, addr);
    if (!mis) begin
      be.addr  = addr & 32'hFFFF_FFFC;
      be.wen   = store;
      be.mask  = store ? model_mask(size, addr) : 4'd0;
      be.wdata = model_lanes(size, wdata);
      bus_q.push_back(be);
    end
    re.rdata = (store || mis) ? 32'd0 : model_load(size, uns, addr, rdata);
    re.err   = mis;
    resp_q.push_back(re);

    if (issue) begin
      bus.reqValid    = 1'b1;
      bus.reqStore    = store;
      bus.reqSize     = size;
      bus.reqUnsigned = uns;
      bus.reqAddr     = addr;
      bus.reqWdata    = wdata;
    end
    step();
    if (!hold) begin
      bus.reqValid    = 1'b0;
      bus.reqStore    = 1'($urandom);
      bus.reqSize     = 2'($urandom);
      bus.reqUnsigned = 1'($urandom);
      bus.reqAddr     = $urandom;
      bus.reqWdata    = $urandom;
    end
    if (!mis) begin
      n = 0;
      while (!bus.mem_reqValid && n < 20) begin
        step();
        n++;
      end
      if (!bus.mem_reqValid) fail_now("timeout_mem_reqValid");
      repeat (rdly) step();
      bus.mem_reqReady = 1'b1;
      if (glitch) begin
        bus.mem_respValid = 1'b1;
        bus.mem_rdata     = $urandom;
      end
      step();
      bus.mem_reqReady  = 1'b0;
      bus.mem_respValid = 1'b0;
      repeat (pdly) step();
      bus.mem_respValid = 1'b1;
      bus.mem_rdata     = rdata;
      step();
      bus.mem_respValid = 1'b0;
      bus.mem_rdata     = $urandom;
    end
    wait_resp();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_respValid"}, 32'(bus.respValid), 32'd0);
    check({tag, "_respRdata"}, bus.respRdata, 32'd0);
    check({tag, "_respErr"}, 32'(bus.respErr), 32'd0);
    check({tag, "_mem_reqValid"}, 32'(bus.mem_reqValid), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wen"}, 32'(bus.mem_wen), 32'd0);
    check({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, acc0, rs0;
    bus.reqValid = 1'b0; bus.reqStore = 1'b0; bus.reqSize = 2'd0; bus.reqUnsigned = 1'b0;
    bus.reqAddr = '0; bus.reqWdata = '0;
    bus.mem_reqReady = 1'b0; bus.mem_respValid = 1'b0; bus.mem_rdata = '0;
    reset = 1'b1;
    step();
    step();
    @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    step();

    // store word with delayed ready
    txn(1, 1, LSU_SIZE_WORD, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 2, 0, 0, 0);
    check("sw_valid_len", 32'(valid_len), 32'd3);
    check("sw_addr", last_addr, 32'h100);
    check("sw_mask", 32'(last_mask), 32'hF);

    // signed and unsigned byte load from the top lane
    txn(1, 0, LSU_SIZE_BYTE, 0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 0, 0);
    check("lb_signed", bus.respRdata, 32'hFFFF_FF80);
    txn(1, 0, LSU_SIZE_BYTE, 1, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 0, 1);
    check("lb_unsigned", bus.respRdata, 32'h0000_0080);

    // half store to upper lanes
    txn(1, 1, LSU_SIZE_HALF, 0, 32'h202, 32'hABCD_1234, 32'h0, 0, 0, 0, 0);
    check("sh_mask", 32'(last_mask), 32'hC);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    check("sh_addr", last_addr, 32'h200);

    // minimum latency
    c0 = cyc;
    txn(1, 0, LSU_SIZE_WORD, 0, 32'h40, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0);
    check("lat_mem_reqValid", 32'(first_bus_cyc), 32'(c0 + 1));
    check("lat_respValid", 32'(resp_cyc), 32'(c0 + 3));

    // reqValid held: one transaction, then a second starts after RESP
    acc0 = bus_accepts;
    rs0  = resp_seen;
    txn(1, 1, LSU_SIZE_BYTE, 0, 32'h301, 32'h0000_00A5, 32'h0, 1, 1, 1, 0);
    check("hold_one_bus", 32'(bus_accepts - acc0), 32'd1);
    check("hold_one_resp", 32'(resp_seen - rs0), 32'd1);
    txn(0, 1, LSU_SIZE_BYTE, 0, 32'h301, 32'h0000_00A5, 32'h0, 0, 0, 0, 0);
    repeat (4) step();
    check("hold_two_bus", 32'(bus_accepts - acc0), 32'd2);
    check("hold_two_resp", 32'(resp_seen - rs0), 32'd2);

    // misaligned word load
    c0   = cyc;
    acc0 = bus_accepts;
    txn(1, 0, LSU_SIZE_WORD, 0, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_EN
    check("mis_lat", 32'(resp_cyc), 32'(c0 + 1));
    check("mis_err", 32'(last_err), 32'd1);
    check("mis_no_bus", 32'(bus_accepts - acc0), 32'd0);
`else
    check("mis_addr", last_addr, 32'h100);
    check("mis_rdata", bus.respRdata, 32'hCAFE_F00D);
`endif

    // reset while waiting for the bus response
    bus_q.push_back('{addr: 32'h500, wen: 1'b0, mask: 4'd0, wdata: 32'd0});
    rs0 = resp_seen;
    bus.reqValid = 1'b1; bus.reqStore = 1'b0; bus.reqSize = LSU_SIZE_WORD;
    bus.reqUnsigned = 1'b0; bus.reqAddr = 32'h500;
    step();
    bus.reqValid = 1'b0;
    bus.mem_reqReady = 1'b1;
    step();
    bus.mem_reqReady = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_zero("midrst");
    step();
    reset = 1'b0;
    bus.mem_respValid = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_respValid = 1'b0;
    repeat (4) step();
    check("midrst_no_resp", 32'(resp_seen - rs0), 32'd0);
    check("midrst_mem_reqValid", 32'(bus.mem_reqValid), 32'd0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      txn(1, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 1'($urandom));
    end
    repeat (4) step();
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the multi-cycle core, sitting directly downstream of the core control state machine. It accepts one load or store request from the controller, performs a single data-memory bus transaction with byte-lane steering, and returns a one-cycle response carrying the sign- or zero-extended load data. The controller holds in its LOAD/STORE state until `respValid`.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- `clock`  in  1  core clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `reqValid`  in  1  request strobe from controller; may be held high for several cycles
- `reqStore`  in  1  1 = store, 0 = load
- `reqSize`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- `reqUnsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `reqAddr`  in  32  byte address
- `reqWdata`  in  32  store data, right-aligned
- `respValid`  out  1  one-cycle completion pulse
- `respRdata`  out  32  extended load data; 0 for stores
- `respErr`  out  1  misaligned-access flag; tied 0 unless configured
- `mem_reqValid`  out  1  bus request valid
- `mem_reqReady`  in  1  bus accepts request
- `mem_addr`  out  32  word-aligned address (`reqAddr & ~3`)
- `mem_wen`  out  1  1 = write
- `mem_wmask`  out  4  byte-lane write enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_respValid`  in  1  bus completion
- `mem_rdata`  in  32  raw word read data
- Clock/reset: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `reqValid` = 1 latches all `req*` fields. Next state is REQ, or RESP when the access is misaligned and the misalign check is configured.
- REQ: `mem_reqValid` = 1 with `mem_addr`, `mem_wen`, `mem_wmask` and `mem_wdata` driven from the latched fields and held stable. `mem_reqReady` = 1 moves to WAIT.
- WAIT: `mem_respValid` = 1 captures the steered and extended `mem_rdata` into `respRdata` and moves to RESP.
- RESP: `respValid` = 1 for exactly one cycle, then return to IDLE.
- `reqValid` outside IDLE is ignored. There is no queueing.
- Lane steering uses `off = addr[1:0]`:
  - `wmask` byte = 4'b0001 << off; half = 4'b0011 << off; word = 4'b1111.
  - `wdata` byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}.
- Loads: `mem_rdata >> (8*off)`, then bits [7:0] or [15:0] are extended per `reqUnsigned`. Word loads are passed through unchanged.
- Loads drive `mem_wmask` = 0.

## Timing
- Reset: state IDLE. `respValid`, `respRdata`, `respErr`, `mem_reqValid`, `mem_addr`, `mem_wen`, `mem_wmask` and `mem_wdata` are all 0.
- Minimum latency, with `mem_reqReady` and `mem_respValid` at their earliest: request at cycle 0, `mem_reqValid` at cycle 1, `mem_respValid` at cycle 2, `respValid` at cycle 3.
- `mem_respValid` arriving in the same cycle as REQ acceptance is not legal on the bus and is ignored.
- Reset asserted mid-transaction abandons the transaction. A late `mem_respValid` seen in IDLE or REQ is ignored.
- `respRdata` holds its value until the next RESP.
- `respErr` is valid only while `respValid` = 1.

## Configuration
- Macro: `LSU_MISALIGN_EN`.
- Defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, skips the bus entirely.
  - It goes IDLE → RESP with `respErr` = 1 and `respRdata` = 0.
- Undefined:
  - `respErr` is tied 0.
  - Half accesses use `off = {addr[1],1'b0}` and word accesses use `off = 0`, i.e. the address is force-aligned.
  - The transaction always goes to the bus.

## Structure
- Shared defs header/package: the `reqSize` encodings (`LSU_SIZE_BYTE`, `LSU_SIZE_HALF`, `LSU_SIZE_WORD`) and the LSU state enum.
- One sub-module `lsu_align`: purely combinational, producing wmask/wdata steering and load extraction/extension. It is instantiated once.
- `lsu` keeps the FSM, request latches and bus handshake.

## Test plan
- Store word 0xDEADBEEF to 0x100 with `mem_reqReady` delayed 2 cycles → `mem_reqValid` held 3 cycles with `mem_addr` = 0x100, `wmask` = 4'b1111; `respValid` pulses once; `respRdata` = 0.
- Load byte signed from 0x103 with `mem_rdata` = 0x80FF_0000 → `respRdata` = 0xFFFF_FF80. The same load unsigned → 0x0000_0080.
- Store half 0x1234 to 0x0202 → `wmask` = 4'b1100, `wdata` = 0x1234_1234, `mem_addr` = 0x200.
- `reqValid` held high across the whole transaction → exactly one bus request and one `respValid`. After RESP, a still-high `reqValid` starts a new request.
- Word load at 0x101 → with `LSU_MISALIGN_EN`, `respValid` at cycle 1, `respErr` = 1, no `mem_reqValid`. Without it, a bus read of 0x100 returns the full word.
- Reset asserted in WAIT, then `mem_respValid` pulsed → all outputs 0, and no `respValid` is produced.
